// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
//   Shared widths and helpers for the 3-to-8 one-hot decoder and its
//   one-hot integrity checker.
//   SEL_W : width of the binary select
//   OUT_W : width of the decoded one-hot vector
//   CNT_W : width wide enough to hold a popcount of 0..OUT_W
// -----------------------------------------------------------------------------
package decoder_pkg;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned CNT_W = $clog2(OUT_W + 1);

  // Binary select to active-high one-hot vector.
  function automatic logic [OUT_W-1:0] onehot_of(input logic [SEL_W-1:0] sel);
    return OUT_W'(1) << sel;
  endfunction

endpackage

// File: rtl/decoder_1hot_3to8_onehot_check.sv
// -----------------------------------------------------------------------------
// onehot_check
//   Combinational integrity monitor: flags a qualified vector whose popcount
//   is anything other than exactly one.
//   i_vec   : vector to inspect, active-high polarity
//   i_valid : qualifies i_vec; when low the flag is held low
//   o_bad   : high when i_valid is high and popcount(i_vec) != 1
// -----------------------------------------------------------------------------
module onehot_check
  import decoder_pkg::*;
(
  input  logic [OUT_W-1:0] i_vec,
  input  logic             i_valid,
  output logic             o_bad
);

  logic [CNT_W-1:0] w_cnt;

  always_comb begin
    w_cnt = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      w_cnt = w_cnt + CNT_W'(i_vec[i]);
    end
    o_bad = i_valid && (w_cnt != CNT_W'(1));
  end

endmodule

// File: rtl/decoder_1hot_3to8.sv
// -----------------------------------------------------------------------------
// decoder_1hot_3to8
//   3-to-8 one-hot decoder with enable, optional output register, selectable
//   output polarity and a sticky one-hot integrity flag.
//   Parameters:
//     OUT_ACTIVE_LOW : 0 = selected bit high, 1 = selected bit low
//     REG_OUT        : 1 = registered outputs (1-cycle latency), 0 = comb
//   Ports:
//     clk       : rising-edge clock
//     rst       : synchronous active-high reset
//     in        : binary select 0..7
//     en        : decode enable
//     out       : decoded one-hot vector (polarity per OUT_ACTIVE_LOW)
//     out_valid : out carries a decode of an enabled input
//     err       : sticky, set if out was ever not one-hot while valid
// -----------------------------------------------------------------------------
module decoder_1hot_3to8
  import decoder_pkg::*;
#(
  parameter bit OUT_ACTIVE_LOW = 1'b0,
  parameter bit REG_OUT        = 1'b1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] in,
  input  logic             en,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic             err
);

  logic [OUT_W-1:0] w_dec;
  logic [OUT_W-1:0] w_norm;
  logic [OUT_W-1:0] w_mon;
  logic             w_vld;
  logic             w_bad;
  logic             r_err;

  assign w_dec = en ? onehot_of(in) : '0;

  if (REG_OUT) begin : g_reg
    logic [OUT_W-1:0] r_dec;
    logic             r_vld;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_dec <= '0;
        r_vld <= 1'b0;
      end else begin
        r_dec <= w_dec;
        r_vld <= en;
      end
    end

    assign w_norm = r_dec;
    assign w_vld  = r_vld;
  end else begin : g_comb
    // Pure combinational path: reset only clears the sticky error flag.
    assign w_norm = w_dec;
    assign w_vld  = en;
  end

  assign out       = OUT_ACTIVE_LOW ? ~w_norm : w_norm;
  assign out_valid = w_vld;

  // Re-normalise from the actual output pins so a polarity fault is visible.
  assign w_mon = OUT_ACTIVE_LOW ? ~out : out;

  onehot_check u_onehot_check (
    .i_vec   (w_mon),
    .i_valid (w_vld),
    .o_bad   (w_bad)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_bad) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_decoder_1hot_3to8.sv
module tb_decoder_1hot_3to8;

  logic       clk;
  logic       rst;
  logic [2:0] r_in;
  logic       en;

  logic [7:0] out_h, out_l, out_c;
  logic       vld_h, vld_l, vld_c;
  logic       err_h, err_l, err_c;

  int unsigned n_checks;
  int unsigned n_errors;

  // Reference model state: registered decode seen after the last edge.
  logic [7:0] onehot_tbl [8];
  logic [7:0] m_out;
  logic       m_vld;

  decoder_1hot_3to8 #(.OUT_ACTIVE_LOW(1'b0), .REG_OUT(1'b1)) dut_h (
    .clk(clk), .rst(rst), .in(r_in), .en(en),
    .out(out_h), .out_valid(vld_h), .err(err_h)
  );

  decoder_1hot_3to8 #(.OUT_ACTIVE_LOW(1'b1), .REG_OUT(1'b1)) dut_l (
    .clk(clk), .rst(rst), .in(r_in), .en(en),
    .out(out_l), .out_valid(vld_l), .err(err_l)
  );

  decoder_1hot_3to8 #(.OUT_ACTIVE_LOW(1'b0), .REG_OUT(1'b0)) dut_c (
    .clk(clk), .rst(rst), .in(r_in), .en(en),
    .out(out_c), .out_valid(vld_c), .err(err_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus; check the combinational instance before the
  // edge and the registered instances just after it.
  task automatic cycle(input logic [2:0] a, input logic e, input logic r);
    logic [7:0] exp_now;
    @(negedge clk);
    r_in = a;
    en   = e;
    rst  = r;
    exp_now = e ? onehot_tbl[a] : 8'h00;
    #1;
    check("comb_out", 32'(out_c), 32'(exp_now));
    check("comb_vld", 32'(vld_c), 32'(e));

    @(posedge clk);
    if (r) begin
      m_out = 8'h00;
      m_vld = 1'b0;
    end else begin
      m_out = exp_now;
      m_vld = e;
    end
    #1;
    check("reg_out",  32'(out_h), 32'(m_out));
    check("reg_vld",  32'(vld_h), 32'(m_vld));
    check("low_out",  32'(out_l), 32'(8'hFF ^ m_out));
    check("low_vld",  32'(vld_l), 32'(m_vld));
    check("err_h",    32'(err_h), 32'(0));
    check("err_l",    32'(err_l), 32'(0));
    check("err_c",    32'(err_c), 32'(0));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int k = 0; k < 8; k++) onehot_tbl[k] = 8'(2 ** k);
    m_out = 8'h00;
    m_vld = 1'b0;
    r_in  = 3'd0;
    en    = 1'b0;
    rst   = 1'b1;

    // Reset, with en asserted on the second cycle to exercise rst priority.
    cycle(3'd0, 1'b0, 1'b1);
    cycle(3'd5, 1'b1, 1'b1);

    // Full sweep, ten cycles per code.
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 10; j++)
        cycle(3'(k), 1'b1, 1'b0);

    // Disabled decode with a non-zero select.
    cycle(3'd5, 1'b0, 1'b0);
    cycle(3'd5, 1'b0, 1'b0);

    // Back-to-back extremes.
    cycle(3'd7, 1'b1, 1'b0);
    cycle(3'd0, 1'b1, 1'b0);
    cycle(3'd7, 1'b1, 1'b0);
    cycle(3'd0, 1'b1, 1'b0);

    // Reset mid-sweep at in=4, then resume.
    cycle(3'd2, 1'b1, 1'b0);
    cycle(3'd3, 1'b1, 1'b0);
    cycle(3'd4, 1'b1, 1'b1);
    cycle(3'd5, 1'b1, 1'b0);
    cycle(3'd6, 1'b1, 1'b0);
    cycle(3'd2, 1'b1, 1'b0);

    // Randomized traffic with occasional reset and disable.
    for (int j = 0; j < 300; j++)
      cycle(3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/decoder_1hot_3to8.md
DECODER_1HOT_3TO8 -- requirements
Module: decoder_1hot_3to8

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst as in the rest of the codebase.
REQ-002 Parameter OUT_ACTIVE_LOW, default 0: 0 = selected output bit is 1, others 0; 1 = selected bit is 0, others 1.
REQ-003 Parameter REG_OUT, default 1: 1 = registered outputs, 1-cycle latency; 0 = combinational decode of the inputs, 0-cycle latency.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in  input  3  binary select, 0..7.
REQ-007 en  input  1  decode enable; when 0, no output line is active.
REQ-008 out  output  8  one-hot decoded select; bit k active iff in==k and en==1.
REQ-009 out_valid  output  1  high when out carries a decode of an enabled input.
REQ-010 err  output  1  sticky flag: out was ever observed not one-hot while out_valid was high.

Function
REQ-011 Active-high polarity: out SHALL equal 8'b1 << in when en=1, and 8'h00 when en=0.
REQ-012 Active-low polarity: out SHALL be the bitwise inverse of the REQ-011 value, so en=0 gives 8'hFF.
REQ-013 REG_OUT=1: out and out_valid SHALL reflect in and en sampled at the previous rising clk edge.
REQ-014 REG_OUT=0: out and out_valid SHALL follow in and en combinationally, and rst SHALL affect only err.
REQ-015 out_valid SHALL equal the sampled en (REG_OUT=1) or the current en (REG_OUT=0).
REQ-016 When valid, exactly one out bit SHALL be active, for all 8 input codes, with no encoding gaps.
REQ-017 in may change every cycle; each sampled value SHALL appear on out exactly one cycle later, with no skipped or merged codes.
REQ-018 X/Z on in while en=1 is illegal stimulus; the block need not define out for it.
REQ-019 err SHALL be set on the first clk edge at which out_valid=1 and the normalised out (inverted when active-low) does not have exactly one bit set.
REQ-020 err SHALL stay set until rst; in a correct design it never asserts.
REQ-021 When rst and en are both high at the same edge, rst SHALL take priority.

Reset
REQ-022 While rst is sampled high, out SHALL go to its inactive value: 8'h00, or 8'hFF when active-low.
REQ-023 While rst is sampled high, out_valid and err SHALL go to 0.
REQ-024 Reset mid-stream SHALL discard any pending decode.
REQ-025 After rst is released, the first valid output SHALL appear one cycle after the first edge with en=1.
REQ-026 The block SHALL contain no asynchronous reset paths.

Structure
REQ-027 A shared package decoder_pkg SHALL define SEL_W=3, OUT_W=8 and a function onehot_of(sel) returning 1 << sel.
REQ-028 Sub-module onehot_check SHALL take an 8-bit vector and a valid input and flag when the popcount is not 1.
REQ-029 The top level SHALL instantiate onehot_check once, monitoring the normalised out.
REQ-030 The output register, polarity inversion and the REG_OUT generate branches SHALL live in the top level.

Verification
REQ-031 Sweep in=0..7, en=1, 10 cycles each, REG_OUT=1: out = 01,02,04,08,10,20,40,80 (hex), each one cycle after its input; out_valid=1; err=0.
REQ-032 en=0 with in=3'b101: next cycle out=8'h00 and out_valid=0; with OUT_ACTIVE_LOW=1, out=8'hFF.
REQ-033 Back-to-back in=7,0,7,0 with en=1: out=80,01,80,01 on consecutive cycles, no glitch cycle.
REQ-034 rst asserted mid-sweep at in=4: next edge gives out=00, out_valid=0, err=0; decoding resumes one cycle after rst falls.
REQ-035 OUT_ACTIVE_LOW=1, in=2, en=1: out=8'hFB one cycle later.
REQ-036 REG_OUT=0, in=6, en=1: out=8'h40 in the same cycle.
